// File: rtl/int_ctrl.sv
// Edge-triggered interrupt controller: captures rising edges on 8 lines, requests the
// lowest-numbered enabled pending source, and tracks one non-nested handler in service.
module int_ctrl #(
    parameter int unsigned N_SRC    = 8,
    parameter logic [31:0] VEC_BASE = 32'h0000_0080
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq,
    input  logic             en_we,
    input  logic [N_SRC-1:0] en_wdata,
    output logic [N_SRC-1:0] int_en,
    output logic [N_SRC-1:0] pending,
    output logic             int_req,
    input  logic             int_ack,
    output logic [2:0]       int_id,
    output logic [31:0]      int_vec,
    input  logic             eret,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    state_t           state_q;
    logic [N_SRC-1:0] irq_prev_q;
    logic [N_SRC-1:0] pending_q;
    logic [N_SRC-1:0] pending_d;
    logic [N_SRC-1:0] int_en_q;
    logic [2:0]       int_id_q;
    logic             int_req_q;
    logic             busy_q;

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] sel;
    logic [N_SRC-1:0] clr;
    logic [2:0]       sel_id;
    logic             sel_found;

    assign rise = irq & ~irq_prev_q;
    assign sel  = pending_q & int_en_q;

    always_comb begin
        sel_id    = '0;
        sel_found = 1'b0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (sel[i] && !sel_found) begin
                sel_id    = 3'(i);
                sel_found = 1'b1;
            end
        end
    end

    // A fresh edge in the acknowledge cycle wins over the clear, so it is not lost.
    always_comb begin
        clr = '0;
        if (state_q == REQ && int_ack) begin
            clr[int_id_q] = 1'b1;
        end
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            irq_prev_q <= '0;
            pending_q  <= '0;
            int_en_q   <= '0;
            int_id_q   <= '0;
            int_req_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            irq_prev_q <= irq;
            pending_q  <= pending_d;
            if (en_we) begin
                int_en_q <= en_wdata;
            end
            case (state_q)
                IDLE: begin
                    if (sel_found) begin
                        state_q   <= REQ;
                        int_id_q  <= sel_id;
                        int_req_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        state_q   <= SERVICE;
                        int_req_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                SERVICE: begin
                    if (eret) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    int_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign int_en  = int_en_q;
    assign pending = pending_q;
    assign int_req = int_req_q;
    assign int_id  = int_id_q;
    assign busy    = busy_q;
    assign int_vec = VEC_BASE + 32'({int_id_q, 3'b000});

endmodule

// File: tb/tb_int_ctrl.sv
// Directed-vector bench for int_ctrl; expected values are hand-computed per scenario.
module tb_int_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  irq;
    logic        en_we;
    logic [7:0]  en_wdata;
    logic [7:0]  int_en;
    logic [7:0]  pending;
    logic        int_req;
    logic        int_ack;
    logic [2:0]  int_id;
    logic [31:0] int_vec;
    logic        eret;
    logic        busy;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    int_ctrl #(
        .N_SRC   (8),
        .VEC_BASE(32'h0000_0080)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .irq     (irq),
        .en_we   (en_we),
        .en_wdata(en_wdata),
        .int_en  (int_en),
        .pending (pending),
        .int_req (int_req),
        .int_ack (int_ack),
        .int_id  (int_id),
        .int_vec (int_vec),
        .eret    (eret),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_en(input logic [7:0] v);
        en_we    = 1'b1;
        en_wdata = v;
        step();
        en_we    = 1'b0;
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
    endtask

    task automatic pulse_eret();
        eret = 1'b1;
        step();
        eret = 1'b0;
    endtask

    initial begin
        rst = 1'b0; irq = '0; en_we = 1'b0; en_wdata = '0; int_ack = 1'b0; eret = 1'b0;
        #12;
        check("rst_req",  {31'd0, int_req}, 32'd0);
        check("rst_busy", {31'd0, busy},    32'd0);
        check("rst_pend", {24'd0, pending}, 32'h00);
        check("rst_en",   {24'd0, int_en},  32'h00);
        check("rst_id",   {29'd0, int_id},  32'd0);
        check("rst_vec",  int_vec,          32'h0000_0080);
        step();
        rst = 1'b1;

        // Single source: request two edges after the rising irq.
        write_en(8'hFF);
        check("en_ff", {24'd0, int_en}, 32'hFF);
        irq = 8'h08;
        step();
        irq = 8'h00;
        check("t1_pend", {24'd0, pending}, 32'h08);
        check("t1_req0", {31'd0, int_req}, 32'd0);
        step();
        check("t1_req1", {31'd0, int_req}, 32'd1);
        check("t1_id",   {29'd0, int_id},  32'd3);
        check("t1_vec",  int_vec,          32'h0000_0098);
        step();
        check("t1_hold", {31'd0, int_req}, 32'd1);
        pulse_ack();
        check("t1_ackreq", {31'd0, int_req}, 32'd0);
        check("t1_busy",   {31'd0, busy},    32'd1);
        check("t1_clr",    {24'd0, pending}, 32'h00);
        pulse_eret();
        check("t1_idle", {31'd0, busy}, 32'd0);

        // Simultaneous edges: lowest index first, then the other after eret.
        irq = 8'h24;
        step();
        irq = 8'h00;
        step();
        check("t2_id2",  {29'd0, int_id},  32'd2);
        check("t2_vec2", int_vec,          32'h0000_0090);
        pulse_ack();
        check("t2_pend", {24'd0, pending}, 32'h20);
        pulse_eret();
        check("t2_gap", {31'd0, int_req}, 32'd0);
        step();
        check("t2_req5", {31'd0, int_req}, 32'd1);
        check("t2_id5",  {29'd0, int_id},  32'd5);
        check("t2_vec5", int_vec,          32'h0000_00A8);
        pulse_ack();
        pulse_eret();
        check("t2_pend0", {24'd0, pending}, 32'h00);

        // Disabled source stays pending until enabled; selection frozen in REQ.
        write_en(8'h00);
        irq = 8'h02;
        step();
        irq = 8'h00;
        step();
        step();
        check("t3_pend", {24'd0, pending}, 32'h02);
        check("t3_noreq", {31'd0, int_req}, 32'd0);
        write_en(8'h02);
        check("t3_req_lat", {31'd0, int_req}, 32'd0);
        step();
        check("t3_req", {31'd0, int_req}, 32'd1);
        check("t3_id",  {29'd0, int_id},  32'd1);
        en_we = 1'b1; en_wdata = 8'hFF; irq = 8'h01;
        step();
        en_we = 1'b0; irq = 8'h00;
        check("t3_stable_id", {29'd0, int_id},  32'd1);
        check("t3_pend2",     {24'd0, pending}, 32'h03);
        pulse_ack();
        pulse_eret();
        step();
        check("t3_id0", {29'd0, int_id}, 32'd0);
        pulse_ack();
        pulse_eret();

        // Edge in the ack cycle survives the clear; no nesting while in service.
        irq = 8'h10;
        step();
        irq = 8'h00;
        step();
        check("t4_id4", {29'd0, int_id}, 32'd4);
        irq = 8'h10;
        pulse_ack();
        check("t4_pend", {24'd0, pending}, 32'h10);
        check("t4_busy", {31'd0, busy},    32'd1);
        step();
        check("t4_nonest", {31'd0, int_req}, 32'd0);
        pulse_eret();
        step();
        check("t4_rereq", {31'd0, int_req}, 32'd1);
        check("t4_reid",  {29'd0, int_id},  32'd4);

        // eret in REQ and int_ack in IDLE are ignored.
        pulse_eret();
        check("t5_eret_req", {31'd0, int_req}, 32'd1);
        check("t5_eret_bsy", {31'd0, busy},    32'd0);
        pulse_ack();
        irq = 8'h00;
        pulse_eret();
        pulse_ack();
        check("t5_ack_idle_req", {31'd0, int_req}, 32'd0);
        check("t5_ack_idle_bsy", {31'd0, busy},    32'd0);

        // Asynchronous reset mid-service, then a line high at release.
        irq = 8'h08;
        step();
        irq = 8'h02;
        step();
        irq = 8'h00;
        pulse_ack();
        check("t6_busy", {31'd0, busy},    32'd1);
        check("t6_pend", {24'd0, pending}, 32'h02);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_busy", {31'd0, busy},    32'd0);
        check("t6_rst_pend", {24'd0, pending}, 32'h00);
        check("t6_rst_en",   {24'd0, int_en},  32'h00);
        check("t6_rst_id",   {29'd0, int_id},  32'd0);
        irq = 8'h40;
        step();
        rst = 1'b1;
        step();
        check("t7_cap", {24'd0, pending}, 32'h40);
        check("t7_noreq", {31'd0, int_req}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish within 100us");
        $fatal(1);
    end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter N_SRC, default 8, SHALL set the number of interrupt sources (fixed at 8 for this release; int_id is 3 bits).
REQ-002 Parameter VEC_BASE, default 32'h0000_0080, SHALL set the base address of the handler vector table.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1, the single clock, rising-edge active.
REQ-005 Port rst, input, 1, asynchronous active-low reset.
REQ-006 Port irq, input, 8, raw interrupt lines, already synchronous to clk; a rising edge requests service.
REQ-007 Port en_we, input, 1, write strobe for the enable register.
REQ-008 Port en_wdata, input, 8, new enable value; bit i=1 enables source i.
REQ-009 Port int_en, output, 8, current enable register.
REQ-010 Port pending, output, 8, captured-but-unserviced edges.
REQ-011 Port int_req, output, 1, interrupt request to CPU, registered.
REQ-012 Port int_ack, input, 1, CPU acknowledge, 1-cycle pulse.
REQ-013 Port int_id, output, 3, index of the requested/serviced source.
REQ-014 Port int_vec, output, 32, handler address for int_id.
REQ-015 Port eret, input, 1, CPU return-from-handler pulse.
REQ-016 Port busy, output, 1, high while a handler is in service.

Function
REQ-017 irq_d SHALL register irq every cycle; edge[i] = irq[i] & ~irq_d[i].
REQ-018 pending SHALL update each edge as (pending & ~clr) | edge; a set SHALL win over a clear on the same bit in the same cycle.
REQ-019 Edges SHALL be captured in all states, regardless of int_en.
REQ-020 int_en SHALL load en_wdata on any cycle with en_we=1, in any state.
REQ-021 FSM states SHALL be IDLE, REQ, SERVICE.
REQ-022 IDLE: if (pending & int_en) != 0, next state is REQ and int_id latches the lowest set index of (pending & int_en); otherwise stay in IDLE.
REQ-023 REQ: int_req=1; int_id and int_vec SHALL stay stable until int_ack; later edges or int_en writes SHALL NOT change the selection.
REQ-024 REQ with int_ack=1: clear pending[int_id] via clr and go to SERVICE next cycle; int_req drops that same edge.
REQ-025 SERVICE: busy=1, int_req=0, no nesting; eret=1 returns to IDLE next cycle.
REQ-026 int_ack outside REQ and eret outside SERVICE SHALL be ignored.
REQ-027 Latency: irq rising before edge k sets pending after edge k; int_req is high after edge k+1 if the source is enabled and the FSM was IDLE.
REQ-028 After eret, IDLE SHALL spend at least one cycle before int_req reasserts.
REQ-029 int_vec SHALL equal VEC_BASE + {int_id, 3'b000}, 32-bit modulo wrap.
REQ-030 An edge on a source whose pending bit is already set SHALL be merged and not counted.

Reset
REQ-031 rst low SHALL immediately force state=IDLE, pending=0, irq_d=0, int_en=0, int_id=0, int_req=0, busy=0, mid-operation included.
REQ-032 Because irq_d resets to 0, a line already high at reset release SHALL be captured as an edge on the first clock edge.

Verification
REQ-033 Reset, en=8'hFF, pulse irq[3] -> int_req high 2 edges later, int_id=3, int_vec=32'h0000_0098.
REQ-034 irq[5] and irq[2] rise together, en=8'hFF -> int_id=2 first; after ack+eret, int_id=5 requested; pending ends 8'h00.
REQ-035 en=8'h00, pulse irq[1] -> pending=8'h02, int_req stays 0; write en=8'h02 -> int_req high one edge later.
REQ-036 New irq[4] edge in the same cycle as int_ack for id 4 -> pending[4] stays 1; re-requested after eret.
REQ-037 int_ack in IDLE and eret in REQ -> no state change; rst low during SERVICE -> busy=0, pending=0 immediately.
